down_counter_16: RTL and testbench

- Loadable 16-bit synchronous down-counter/timer. It is the consuming counterpart to the existing free-running up-counter.
- Software or an FSM loads a period, and the block counts down on qualified ticks.
- It raises a one-cycle terminal-count pulse at zero.
- Used for timeouts, delay generation and periodic tick generation in the lab designs.

---
 rtl/down_counter_16.sv | 78 +++++++
 tb/tb_down_counter_16.sv | 109 ++++++++++
 2 files changed

// File: rtl/down_counter_16.sv
// down_counter_16: loadable down-counter/timer with one-cycle terminal-count pulse.
// Ports: clock, reset (sync, active-high), enable (tick qualifier), load/load_value (period),
//        stop (abort, no done), count (current value), busy (RUN), done (terminal pulse).
// Optional: define DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from the stored period.
module down_counter_16 #(
  parameter int BIT_SZ = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [BIT_SZ-1:0] load_value,
  input  logic              stop,
  output logic [BIT_SZ-1:0] count,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [BIT_SZ-1:0] ONE = BIT_SZ'(1);
  state_t state, state_nx;
  logic [BIT_SZ-1:0] count_nx;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [BIT_SZ-1:0] reload, reload_nx;
  logic pulse, pulse_nx;
`endif
  always_comb begin
    state_nx = state;
    count_nx = count;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_nx = reload;
    pulse_nx = 1'b0;
`endif
    if (load) begin
      count_nx = load_value;
      state_nx = load_value == '0 ? DONE : RUN;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_nx = load_value;
`endif
    end else if (state == DONE || (state == RUN && stop)) begin
      state_nx = IDLE;
    end else if (state == RUN && enable) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      // terminal tick wraps to the stored period and stays in RUN
      count_nx = count == ONE ? reload : count - ONE;
      pulse_nx = count == ONE;
`else
      count_nx = count - ONE;
      state_nx = count == ONE ? DONE : RUN;
`endif
    end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    pulse_nx = pulse_nx | (state_nx == DONE);
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload <= '0;
      pulse <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      count <= count_nx;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload <= reload_nx;
      pulse <= pulse_nx;
`endif
    end
  end
  assign busy = state == RUN;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  assign done = pulse;
`else
  assign done = state == DONE;
`endif
endmodule

// File: tb/tb_down_counter_16.sv
// tb_down_counter_16: directed vector bench for down_counter_16.
module tb_down_counter_16;
  logic clock = 1'b0;
  logic reset = 1'b0, enable = 1'b0, load = 1'b0, stop = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count;
  logic busy, done;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst, ld, stp, en;
    logic [15:0] lv, c;
    logic b, d;
  } vec_t;
  vec_t vq[$];
  down_counter_16 dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .stop(stop), .count(count), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  function automatic vec_t v(logic rst, logic ld, logic stp, logic en, logic [15:0] lv,
                             logic [15:0] c, logic b, logic d);
    vec_t x;
    x.rst = rst; x.ld = ld; x.stp = stp; x.en = en; x.lv = lv; x.c = c; x.b = b; x.d = d;
    return x;
  endfunction
  task automatic check(string name, logic [15:0] c, logic b, logic d);
    checks++;
    if (count !== c || busy !== b || done !== d) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
               name, count, busy, done, c, b, d);
    end
  endtask
  task automatic apply(string name, vec_t x);
    reset = x.rst; load = x.ld; stop = x.stp; enable = x.en; load_value = x.lv;
    @(posedge clock);
    #1;
    check(name, x.c, x.b, x.d);
  endtask
  initial begin
    // reset then idle
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 0, 1, 7, 0, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    // one-shot of 5
    vq.push_back(v(0, 1, 0, 1, 5, 5, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 4, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 3, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
    // gated enable
    vq.push_back(v(0, 1, 0, 0, 3, 3, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    // stop and restart, load beats stop
    vq.push_back(v(0, 1, 0, 1, 10, 10, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 9, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 8, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 7, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 6, 1, 0));
    vq.push_back(v(0, 0, 1, 1, 0, 6, 0, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 6, 0, 0));
    vq.push_back(v(0, 1, 1, 0, 2, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 1));
    // load during DONE restarts immediately
    vq.push_back(v(0, 1, 1, 1, 2, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
`endif
    // zero period gives a done pulse without busy
    vq.push_back(v(0, 1, 0, 1, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
    // maximum period, mid-count reload, stop
    vq.push_back(v(0, 1, 0, 1, 16'hFFFF, 16'hFFFF, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 16'hFFFE, 1, 0));
    vq.push_back(v(0, 1, 0, 1, 16'h0009, 16'h0009, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 8, 1, 0));
    vq.push_back(v(0, 0, 1, 1, 0, 8, 0, 0));
    for (int i = 0; i < vq.size(); i++) apply($sformatf("vec%0d", i), vq[i]);
    // reset in the middle of a 100-tick count
    apply("ld100", v(0, 1, 0, 1, 100, 100, 1, 0));
    for (int k = 1; k <= 50; k++)
      apply($sformatf("run100_%0d", k), v(0, 0, 0, 1, 0, 16'(100 - k), 1, 0));
    apply("rst_mid", v(1, 0, 0, 1, 0, 0, 0, 0));
    apply("after_rst", v(0, 0, 0, 1, 0, 0, 0, 0));
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // periodic tick every 4 enabled cycles
    apply("ar_ld", v(0, 1, 0, 1, 4, 4, 1, 0));
    for (int k = 1; k <= 16; k++)
      apply($sformatf("ar_%0d", k),
            v(0, 0, 0, 1, 0, (k % 4 == 0) ? 16'd4 : 16'(4 - k % 4), 1, k % 4 == 0));
    apply("ar_stop", v(0, 0, 1, 1, 0, 4, 0, 0));
    apply("ar1_ld", v(0, 1, 0, 1, 1, 1, 1, 0));
    for (int k = 1; k <= 3; k++) apply($sformatf("ar1_%0d", k), v(0, 0, 0, 1, 0, 1, 1, 1));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
